// File: rtl/alu_logic_pkg.sv
// -----------------------------------------------------------------------------
// alu_logic_pkg
// Shared definitions for the multi-cycle bitwise logic unit:
//   - opcode constants OP_AND .. OP_ANDN (3'b110 and 3'b111 are illegal)
//   - op_is_legal(): legality check used by the controller
//   - state_e: controller FSM state encodings
// -----------------------------------------------------------------------------
package alu_logic_pkg;

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_XOR  = 3'b010;
  localparam logic [2:0] OP_NOR  = 3'b011;
  localparam logic [2:0] OP_XNOR = 3'b100;
  localparam logic [2:0] OP_ANDN = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_e;

  // Every opcode up to and including ANDN is implemented; the top two are not.
  function automatic logic op_is_legal(input logic [2:0] op);
    return (op <= OP_ANDN);
  endfunction

endpackage

// File: rtl/alu_logic_unit_seq_slice.sv
// -----------------------------------------------------------------------------
// logic_slice
// Purely combinational CHUNK-wide bitwise operator. One instance is shared by
// every chunk of the wide datapath.
// Ports:
//   op  in  [2:0]       operation select (alu_logic_pkg opcodes)
//   a   in  [CHUNK-1:0] operand A chunk
//   b   in  [CHUNK-1:0] operand B chunk
//   y   out [CHUNK-1:0] op(a, b); zero for illegal opcodes
// -----------------------------------------------------------------------------
module logic_slice
  import alu_logic_pkg::*;
#(
  parameter int CHUNK = 8
) (
  input  logic [2:0]       op,
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  output logic [CHUNK-1:0] y
);

  always_comb begin
    // NOTE: assigning a default before the case guarantees y is driven on
    // every path, so no latch is inferred for unlisted opcodes.
    y = '0;
    case (op)
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_NOR:  y = ~(a | b);
      OP_XNOR: y = ~(a ^ b);
      OP_ANDN: y = a & ~b;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/alu_logic_unit_seq.sv
// -----------------------------------------------------------------------------
// alu_logic_unit_seq
// Multi-cycle bitwise logic unit. A request (a, b, op) is captured on an
// in_valid/in_ready handshake, then processed CHUNK bits per clock through a
// single logic_slice. The completed result and its flags are held until the
// consumer takes them with out_valid/out_ready. CHUNK must divide WIDTH.
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   asynchronous, active-high reset
//   in_valid   in   request valid
//   in_ready   out  unit can accept a request (IDLE and not in reset)
//   op         in   [2:0] operation select
//   a, b       in   [WIDTH-1:0] operands
//   out_valid  out  result valid (DONE)
//   out_ready  in   consumer accepts result
//   result     out  [WIDTH-1:0] registered result
//   zero       out  result == 0
//   parity     out  XOR-reduction of result
//   err        out  request carried an illegal opcode
// -----------------------------------------------------------------------------
module alu_logic_unit_seq
  import alu_logic_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             parity,
  output logic             err
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] a_q, b_q, result_q, result_next;
  logic [2:0]       op_q;
  logic             zero_q, parity_q, err_q;
  logic [CHUNK-1:0] a_chunk, b_chunk, y_chunk;
  logic             accept, last_chunk;

  // in_ready is gated by rst so it drops the instant reset is asserted.
  assign in_ready   = (state_q == IDLE) && !rst;
  assign accept     = in_valid && in_ready;
  assign last_chunk = (cnt_q == LAST);

  // ---------------------------------------------------------------------------
  // Chunk select: the counter picks which CHUNK-wide slice of the captured
  // operands feeds the shared operator, and which slice of the result it lands in.
  // ---------------------------------------------------------------------------
  always_comb begin
    a_chunk = '0;
    b_chunk = '0;
    for (int i = 0; i < NCHUNK; i++) begin
      if (cnt_q == CW'(i)) begin
        a_chunk = a_q[i*CHUNK +: CHUNK];
        b_chunk = b_q[i*CHUNK +: CHUNK];
      end
    end
  end

  logic_slice #(.CHUNK(CHUNK)) u_slice (
    .op (op_q),
    .a  (a_chunk),
    .b  (b_chunk),
    .y  (y_chunk)
  );

  // Result with the current chunk merged in; flags on entry to DONE are taken
  // from this so they reflect the final chunk written on the same edge.
  always_comb begin
    result_next = result_q;
    for (int i = 0; i < NCHUNK; i++) begin
      if (cnt_q == CW'(i)) begin
        result_next[i*CHUNK +: CHUNK] = y_chunk;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Controller FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept)     state_d = op_is_legal(op) ? BUSY : DONE;
      BUSY: if (last_chunk) state_d = DONE;
      DONE: if (out_ready)  state_d = IDLE;
      default:              state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= OP_AND;
      cnt_q    <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
      parity_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            a_q      <= a;
            b_q      <= b;
            op_q     <= op;
            cnt_q    <= '0;
            result_q <= '0;
            parity_q <= 1'b0;
            // An illegal op goes straight to DONE with a zero result.
            zero_q   <= !op_is_legal(op);
            err_q    <= !op_is_legal(op);
          end
        end
        BUSY: begin
          result_q <= result_next;
          if (last_chunk) begin
            zero_q   <= ~|result_next;
            parity_q <= ^result_next;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        DONE: begin
          if (out_ready) err_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign zero      = zero_q;
  assign parity    = parity_q;
  assign err       = err_q;

endmodule

// File: tb/tb_alu_logic_unit_seq.sv
// -----------------------------------------------------------------------------
// tb_alu_logic_unit_seq
// Directed bench: a table of vectors with hand-computed results, plus sequences
// for backpressure, mid-operation reset and a CHUNK == WIDTH instance.
// Latency below counts clock edges after the acceptance edge until out_valid
// is seen high (legal: NCHUNK, illegal: 0 -> visible the cycle after accept).
// -----------------------------------------------------------------------------
module tb_alu_logic_unit_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, out_ready;
  logic        in_ready, out_valid;
  logic [2:0]  op;
  logic [31:0] a, b, result;
  logic        zero, parity, err;

  logic        in_valid2, out_ready2;
  logic        in_ready2, out_valid2;
  logic [2:0]  op2;
  logic [31:0] a2, b2, result2;
  logic        zero2, parity2, err2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu_logic_unit_seq #(.WIDTH(32), .CHUNK(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .parity(parity), .err(err)
  );

  alu_logic_unit_seq #(.WIDTH(32), .CHUNK(32)) dut_wide (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2), .op(op2),
    .a(a2), .b(b2), .out_valid(out_valid2), .out_ready(out_ready2),
    .result(result2), .zero(zero2), .parity(parity2), .err(err2)
  );

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        z;
    logic        p;
    logic        e;
    int          lat;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Issue one request, wait for the result, check it, then take it.
  task automatic run_vec(input vec_t v);
    int lat;
    bit ready_seen;
    @(negedge clk);
    op = v.op; a = v.a; b = v.b; in_valid = 1'b1;
    check({v.name, "_in_ready_idle"}, {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0; ready_seen = 1'b0;
    while (!out_valid && lat < 50) begin
      if (in_ready) ready_seen = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    check({v.name, "_latency"}, lat, v.lat);
    check({v.name, "_in_ready_busy"}, {31'd0, ready_seen}, 32'd0);
    check({v.name, "_result"}, result, v.res);
    check({v.name, "_zero"},   {31'd0, zero},   {31'd0, v.z});
    check({v.name, "_parity"}, {31'd0, parity}, {31'd0, v.p});
    check({v.name, "_err"},    {31'd0, err},    {31'd0, v.e});
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({v.name, "_out_valid_after_hs"}, {31'd0, out_valid}, 32'd0);
    check({v.name, "_err_after_hs"},       {31'd0, err},       32'd0);
    check({v.name, "_in_ready_after_hs"},  {31'd0, in_ready},  32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int lat;
    vec_t v;

    vecs[0] = '{"xor",   3'b010, 32'hF0F0_1234, 32'h0FF0_00FF, 32'hFF00_12CB, 1'b0, 1'b1, 1'b0, 4};
    vecs[1] = '{"and",   3'b000, 32'hAAAA_AAAA, 32'h5555_5555, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 4};
    vecs[2] = '{"or",    3'b001, 32'h1234_5678, 32'h0000_000F, 32'h1234_567F, 1'b0, 1'b0, 1'b0, 4};
    vecs[3] = '{"nor",   3'b011, 32'hFFFF_FFFE, 32'h0000_0000, 32'h0000_0001, 1'b0, 1'b1, 1'b0, 4};
    vecs[4] = '{"xnor_eq", 3'b100, 32'h1234_5678, 32'h1234_5678, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 4};
    vecs[5] = '{"xnor_1", 3'b100, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0, 1'b1, 1'b0, 4};
    vecs[6] = '{"ill110", 3'b110, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 0};
    vecs[7] = '{"ill111", 3'b111, 32'h1234_5678, 32'h8765_4321, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 0};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; op = 3'b000; a = '0; b = '0;
    in_valid2 = 1'b0; out_ready2 = 1'b0; op2 = 3'b000; a2 = '0; b2 = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready",  {31'd0, in_ready},  32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_result",    result,             32'd0);
    check("rst_flags",     {29'd0, zero, parity, err}, 32'd0);
    @(negedge clk); rst = 1'b0;

    // Table-driven vectors
    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // Backpressure: ANDN held in DONE for 5 cycles while in_valid is high
    @(negedge clk);
    op = 3'b101; a = 32'hFFFF_0000; b = 32'h00FF_00FF; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    check("andn_latency", lat, 4);
    check("andn_result",  result, 32'hFF00_0000);
    @(negedge clk);
    in_valid = 1'b1; op = 3'b010; a = 32'h1111_1111; b = 32'h2222_2222;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      check("bp_result",    result, 32'hFF00_0000);
      check("bp_out_valid", {31'd0, out_valid}, 32'd1);
      check("bp_in_ready",  {31'd0, in_ready},  32'd0);
    end
    check("bp_flags", {29'd0, zero, parity, err}, 32'd0);
    @(negedge clk); in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp_in_ready_after_hs",  {31'd0, in_ready},  32'd1);
    check("bp_out_valid_after_hs", {31'd0, out_valid}, 32'd0);

    // Reset after two chunks of an OR
    @(negedge clk);
    op = 3'b001; a = 32'hFFFF_FFFF; b = 32'h0000_0000; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_result",    result,             32'd0);
    check("mid_rst_flags",     {29'd0, zero, parity, err}, 32'd0);
    check("mid_rst_in_ready",  {31'd0, in_ready},  32'd0);
    @(negedge clk); rst = 1'b0;
    #1;
    check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
    v = '{"or_fresh", 3'b001, 32'h0000_0001, 32'h8000_0000, 32'h8000_0001, 1'b0, 1'b0, 1'b0, 4};
    run_vec(v);

    // CHUNK == WIDTH instance: NOR of zeros, single BUSY cycle
    @(negedge clk);
    check("wide_in_ready", {31'd0, in_ready2}, 32'd1);
    op2 = 3'b011; a2 = 32'h0; b2 = 32'h0; in_valid2 = 1'b1;
    @(posedge clk); #1;
    in_valid2 = 1'b0;
    lat = 0;
    while (!out_valid2 && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    check("wide_latency", lat, 1);
    check("wide_result",  result2, 32'hFFFF_FFFF);
    check("wide_zero",    {31'd0, zero2},   32'd0);
    check("wide_parity",  {31'd0, parity2}, 32'd0);
    check("wide_err",     {31'd0, err2},    32'd0);
    @(negedge clk); out_ready2 = 1'b1;
    @(posedge clk); #1;
    out_ready2 = 1'b0;
    check("wide_out_valid_after_hs", {31'd0, out_valid2}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
